uart_transmitter: RTL and testbench
===================================

# uart_transmitter

Serial transmit stage of the UART. It accepts one byte per valid/ready handshake from the host side and serialises it onto a single line. The frame is a start bit, 8 data bits sent LSB first, an optional even-parity bit, and two stop bits. Its output drives the serial input of the UART receive stage.

## Interface
- CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range ≥ 2.
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- tx_data  input  8  byte to send; sampled only on handshake.
- tx_valid  input  1  upstream has a byte on tx_data.
- tx_ready  output  1  block can accept a byte this cycle.
- tx_out  output  1  serial line; idles high.
- tx_busy  output  1  frame in progress.
- tx_done  output  1  one-cycle pulse at the end of a frame.

## Operation
- **States:** IDLE, START, DATA, PARITY, STOP1, STOP2.
- **Handshake:**
  - tx_ready = 1 only in IDLE; it is combinational from state.
  - A transfer occurs on a rising edge where tx_valid && tx_ready.
  - On transfer: tx_data is copied into an 8-bit shift register, and the parity register is loaded with ^tx_data. State then goes to START.
- **tx_out per state:**
  - IDLE: 1.
  - START: 0.
  - DATA: shift register bit 0; shift right at each bit boundary.
  - PARITY: parity register.
  - STOP1 and STOP2: 1.
- **Bit timing:**
  - Bit counter width is $clog2(CLKS_PER_BIT). It clears on entry to each state.
  - A state lasts exactly CLKS_PER_BIT cycles, then advances.
  - A 3-bit data index counts 0..7. DATA exits after index 7 completes.
- **Transitions:** START→DATA→PARITY→STOP1→STOP2→IDLE. DATA goes to STOP1 directly when parity is compiled out.
- **tx_busy** = (state != IDLE).
- **tx_done** is registered. It is high for exactly the first cycle back in IDLE after STOP2.
- **Boundary conditions:**
  - tx_valid while busy: ignored, no capture. Upstream holds it until tx_ready.
  - tx_data changing mid-frame: no effect on the frame in flight.
  - tx_valid held continuously: exactly one byte accepted per frame.
  - Reset mid-frame: abort. The frame is lost and tx_done is not pulsed.
- **Reset values:** state IDLE, tx_out 1, tx_busy 0, tx_done 0, tx_ready 1, counters and shift register 0.

## Timing
- Accept edge T: tx_out goes 0 in cycle T+1.
- Bit k of the frame occupies cycles T+1+k·CLKS_PER_BIT through T+(k+1)·CLKS_PER_BIT.
- Frame length is N·CLKS_PER_BIT cycles:
  - N = 12 with parity.
  - N = 11 without parity.
- tx_done and tx_ready both assert in cycle T+N·CLKS_PER_BIT+1.
- Back-to-back frames: the earliest next accept is that same cycle. The next start bit begins one cycle later, giving exactly one idle-high cycle between frames.
- Reset takes effect at the edge where rst_n is sampled low. tx_out is 1 from the following cycle.

## Configuration
- **TX_PARITY_EN defined:** the PARITY state is included and the even-parity bit (XOR of the data bits) is transmitted. The frame is 12 bits.
- **TX_PARITY_EN undefined:** the PARITY state and parity register are removed and the frame is 11 bits. The handshake is unchanged.

## Test plan
- **Reset:** hold rst_n low 3 cycles, tx_valid=0 → tx_out=1, tx_busy=0, tx_done=0, tx_ready=1 throughout.
- **Single byte, parity on:** CLKS_PER_BIT=4, send 0xA5 → tx_out bits 0,1,0,1,0,0,1,0,1,0,1,1, each held 4 cycles (48 cycles). tx_done pulses once in the cycle after the last stop bit.
- **Parity value:** send 0x01 → parity bit 1; send 0xFF → parity bit 0.
- **Back-to-back:** tx_valid held high with 0x55 then 0x0F → two frames separated by exactly one idle-high cycle. tx_ready is high for one cycle between them, and exactly two handshakes occur.
- **Reset mid-frame:** assert rst_n low during DATA bit 3 → next cycle tx_out=1, tx_busy=0, no tx_done. A following send of 0x3C transmits correctly.
- **Parity compiled out:** TX_PARITY_EN undefined, CLKS_PER_BIT=4, send 0xA5 → 44-cycle frame with the stop bits immediately after data bit 7.

Source files
------------

// File: rtl/uart_transmitter.sv
// UART transmit serialiser: start bit, 8 data bits LSB first, optional even parity, two stop bits.
// The optional parity bit is controlled by the TX_PARITY_EN macro; when it is undefined the frame is 11 bits.
module uart_transmitter #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       sr;
`ifdef TX_PARITY_EN
    logic             par;
`endif
    logic             bit_end;

    assign tx_ready = (state == IDLE);
    assign bit_end  = (cnt == CNT_W'(CLKS_PER_BIT - 1));

    // Frame sequencer; tx_out is registered so each bit starts on the cycle after its boundary edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            sr      <= '0;
`ifdef TX_PARITY_EN
            par     <= 1'b0;
`endif
            tx_out  <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (state == IDLE) begin
                cnt <= '0;
                if (tx_valid) begin
                    sr      <= tx_data;
`ifdef TX_PARITY_EN
                    par     <= ^tx_data;
`endif
                    idx     <= '0;
                    state   <= START;
                    tx_out  <= 1'b0;
                    tx_busy <= 1'b1;
                end
            end else if (!bit_end) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
                case (state)
                    START: begin
                        state  <= DATA;
                        tx_out <= sr[0];
                    end
                    DATA: begin
                        sr <= {1'b0, sr[7:1]};
                        if (idx == 3'd7) begin
`ifdef TX_PARITY_EN
                            state  <= PARITY;
                            tx_out <= par;
`else
                            state  <= STOP1;
                            tx_out <= 1'b1;
`endif
                        end else begin
                            idx    <= idx + 3'd1;
                            tx_out <= sr[1];
                        end
                    end
`ifdef TX_PARITY_EN
                    PARITY: begin
                        state  <= STOP1;
                        tx_out <= 1'b1;
                    end
`endif
                    STOP1: begin
                        state  <= STOP2;
                        tx_out <= 1'b1;
                    end
                    STOP2: begin
                        state   <= IDLE;
                        tx_out  <= 1'b1;
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                    end
                    default: begin
                        state   <= IDLE;
                        tx_out  <= 1'b1;
                        tx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: table vectors, random bytes, back-to-back and mid-frame reset.
module tb_uart_transmitter;

    localparam int unsigned C = 4;
`ifdef TX_PARITY_EN
    localparam int unsigned NB = 12;
    localparam bit PAR_ON = 1'b1;
`else
    localparam int unsigned NB = 11;
    localparam bit PAR_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_out;
    logic       tx_busy;
    logic       tx_done;

    int errors = 0;
    int checks = 0;
    int hs_count = 0;

    always #5 clk = ~clk;

    uart_transmitter #(.CLKS_PER_BIT(C)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_out   (tx_out),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    always @(posedge clk) begin
        if (rst_n === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1)
            hs_count <= hs_count + 1;
    end

    typedef struct {
        logic [7:0] data;
        logic       parity;
    } vec_t;

    // Reference frame: bit k of the serial frame for byte b with parity p.
    function automatic logic exp_bit(input logic [7:0] b, input logic p, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (PAR_ON && k == 9) return p;
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input logic exp_done);
        chk("idle tx_ready", 8'(tx_ready), 8'(1'b1));
        chk("idle tx_busy",  8'(tx_busy),  8'(1'b0));
        chk("idle tx_out",   8'(tx_out),   8'(1'b1));
        chk("idle tx_done",  8'(tx_done),  8'(exp_done));
    endtask

    // Waits (bounded) for tx_ready and presents a byte before the next rising edge.
    task automatic start_frame(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        chk("tx_done single pulse", 8'(tx_done), 8'(1'b0));
        while (tx_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ready before send", 8'(tx_ready), 8'(1'b1));
        tx_data  = b;
        tx_valid = 1'b1;
    endtask

    // Checks every cycle of a frame accepted at the coming edge, then the done/ready cycle.
    task automatic run_frame(input logic [7:0] b, input logic p, input bit hold_next, input logic [7:0] next_b);
        for (int i = 0; i < int'(NB * C); i++) begin
            @(negedge clk);
            if (hold_next) begin
                tx_data = next_b;
            end else if (i >= int'((NB - 1) * C)) begin
                tx_valid = 1'b0;
            end else begin
                tx_valid = 1'($urandom);
                tx_data  = 8'($urandom);
            end
            chk($sformatf("tx_out bit%0d byte %0h", i / int'(C), b), 8'(tx_out), 8'(exp_bit(b, p, i / int'(C))));
            chk("busy in frame",  8'(tx_busy),  8'(1'b1));
            chk("ready in frame", 8'(tx_ready), 8'(1'b0));
            chk("done in frame",  8'(tx_done),  8'(1'b0));
        end
        @(negedge clk);
        chk_idle(1'b1);
    endtask

    vec_t vecs[8];
    int   h0;
    logic [7:0] rb;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b0};
        vecs[1] = '{8'h01, 1'b1};
        vecs[2] = '{8'hFF, 1'b0};
        vecs[3] = '{8'h3C, 1'b0};
        vecs[4] = '{8'h80, 1'b1};
        vecs[5] = '{8'h07, 1'b1};
        vecs[6] = '{8'h00, 1'b0};
        vecs[7] = '{8'hFE, 1'b1};

        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) begin
            @(negedge clk);
            chk_idle(1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        h0 = hs_count;
        foreach (vecs[i]) begin
            start_frame(vecs[i].data);
            run_frame(vecs[i].data, vecs[i].parity, 1'b0, 8'h00);
        end
        chk("handshakes table", 8'(hs_count - h0), 8'(8));

        // Back-to-back with tx_valid held high across both frames.
        start_frame(8'h55);
        h0 = hs_count;
        run_frame(8'h55, 1'b0, 1'b1, 8'h0F);
        chk("b2b first handshake", 8'(hs_count - h0), 8'(1));
        run_frame(8'h0F, 1'b0, 1'b0, 8'h00);
        chk("b2b two handshakes", 8'(hs_count - h0), 8'(2));

        // Reset during data bit 3.
        start_frame(8'hC3);
        for (int i = 0; i < int'(4 * C + 2); i++) begin
            @(negedge clk);
            tx_valid = 1'b0;
            chk("pre-reset tx_out", 8'(tx_out), 8'(exp_bit(8'hC3, 1'b0, i / int'(C))));
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk_idle(1'b0);
        rst_n = 1'b1;
        repeat (2 * C) begin
            @(negedge clk);
            chk("no done after abort", 8'(tx_done), 8'(1'b0));
            chk("line high after abort", 8'(tx_out), 8'(1'b1));
        end
        start_frame(8'h3C);
        run_frame(8'h3C, 1'b0, 1'b0, 8'h00);

        // Random bytes against the frame model.
        for (int n = 0; n < 20; n++) begin
            rb = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            start_frame(rb);
            run_frame(rb, ^rb, 1'b0, 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
